// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive/transmit slice.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_DATA_BITS    = 8;
  localparam int MAX_DATA_BITS        = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Parity bit a transmitter would send for these data bits; unused upper bits must be zero.
  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_core_sync2.sv
// Two-flop synchroniser for a single asynchronous input, with a configurable reset value.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start/data/parity/stop sampling at mid-bit, one-entry valid/ready output.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 clr_overrun,
  output logic                 busy
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

  logic                 rxs;
  logic                 rxs_prev;
  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 bit_tick;
  logic                 frame_done;
  logic                 stop_err;
  logic                 load;

  sync2 #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rxs)
  );

  assign bit_tick = (div_q == '0);
  assign busy     = (state_q != IDLE);
  // A finished frame is taken if the holding register is free or being drained this cycle.
  assign load     = frame_done && (!m_valid || m_ready);

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case infers a latch.
    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    frame_done = 1'b0;
    stop_err   = 1'b0;

    if (state_q != IDLE && !bit_tick) begin
      div_d = div_q - 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (rxs_prev && !rxs) begin
          state_d = START;
          div_d   = DIV_HALF;
        end
      end
      START: begin
        if (bit_tick) begin
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            div_d   = DIV_FULL;
            cnt_d   = '0;
            perr_d  = 1'b0;
          end
        end
      end
      DATA: begin
        if (bit_tick) begin
          div_d   = DIV_FULL;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            if (PARITY_EN) state_d = PARITY;
            else           state_d = STOP;
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          div_d   = DIV_FULL;
          perr_d  = (rxs != parity_of(MAX_DATA_BITS'(shift_q), PARITY_ODD));
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          frame_done = 1'b1;
          stop_err   = !rxs;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      perr_q   <= 1'b0;
      rxs_prev <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      perr_q   <= perr_d;
      rxs_prev <= rxs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data     <= '0;
      m_valid    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        m_data     <= shift_q;
        frame_err  <= stop_err;
        parity_err <= perr_q;
        m_valid    <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      // Setting takes priority over a simultaneous clear.
      if (frame_done && !load) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: one instance without parity, one with even parity.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int CPB   = 16;
  localparam int DB    = 8;
  localparam bit P_ODD = 1'b0;
  // Two sync flops, half a bit to mid-start, 9 more bits to mid-stop, one cycle to load.
  localparam int EXP_LAT = 2 + CPB / 2 + (DB + 1) * CPB + 1;

  typedef struct {
    bit         sel;
    logic [7:0] data;
    bit         pbit;
    bit         stopb;
    logic [7:0] exp_data;
    bit         exp_ferr;
    bit         exp_perr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic m_ready0 = 1'b0, m_ready1 = 1'b0;
  logic clr_overrun = 1'b0;

  logic [DB-1:0] d0_data, d1_data;
  logic d0_valid, d0_ferr, d0_perr, d0_ovr, d0_busy;
  logic d1_valid, d1_ferr, d1_perr, d1_ovr, d1_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .m_data(d0_data), .m_valid(d0_valid),
    .m_ready(m_ready0), .frame_err(d0_ferr), .parity_err(d0_perr), .overrun(d0_ovr),
    .clr_overrun(clr_overrun), .busy(d0_busy)
  );

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_EN(1'b1), .PARITY_ODD(P_ODD)) dut_p (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .m_data(d1_data), .m_valid(d1_valid),
    .m_ready(m_ready1), .frame_err(d1_ferr), .parity_err(d1_perr), .overrun(d1_ovr),
    .clr_overrun(clr_overrun), .busy(d1_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] data, input bit pbit, input bit stopb);
    logic [10:0] fr;
    int nb;
    nb = sel ? 11 : 10;
    fr = sel ? {stopb, pbit, data, 1'b0} : {1'b1, stopb, data, 1'b0};
    for (int i = 0; i < nb; i++) begin
      if (sel) rx1 = fr[i]; else rx0 = fr[i];
      ticks(CPB);
    end
    if (sel) rx1 = 1'b1; else rx0 = 1'b1;
  endtask

  task automatic wait_valid(input bit sel, input string name);
    int n;
    n = 0;
    while (!(sel ? d1_valid : d0_valid) && n < 4 * CPB) begin
      tick();
      n++;
    end
    check({name, " valid"}, sel ? d1_valid : d0_valid, 1'b1);
  endtask

  task automatic check_hold(input bit sel, input string name, input logic [7:0] data,
                            input bit ferr, input bit perr);
    check({name, " data"}, sel ? d1_data : d0_data, data);
    check({name, " frame_err"}, sel ? d1_ferr : d0_ferr, ferr);
    check({name, " parity_err"}, sel ? d1_perr : d0_perr, perr);
  endtask

  task automatic consume(input bit sel, input string name);
    if (sel) m_ready1 = 1'b1; else m_ready0 = 1'b1;
    tick();
    if (sel) m_ready1 = 1'b0; else m_ready0 = 1'b0;
    check({name, " consumed"}, sel ? d1_valid : d0_valid, 1'b0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " m_valid"}, d0_valid, 1'b0);
    check({name, " m_data"}, d0_data, 8'h00);
    check({name, " frame_err"}, d0_ferr, 1'b0);
    check({name, " parity_err"}, d0_perr, 1'b0);
    check({name, " overrun"}, d0_ovr, 1'b0);
    check({name, " busy"}, d0_busy, 1'b0);
  endtask

  initial begin
    #900_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[8];
    logic [7:0] rv;
    int lat, brk_cnt;
    logic [7:0] brk_data;
    logic brk_ferr;
    bit mfull, mferr, movr;
    logic [7:0] mdata;

    tbl[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'h80, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};

    // Reset state
    ticks(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    ticks(4);

    // Exact latency with the consumer always ready
    m_ready0 = 1'b1;
    fork
      send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
      begin
        lat = 0;
        while (!d0_valid && lat < 400) begin
          tick();
          lat++;
        end
        check("latency", lat, EXP_LAT);
        check_hold(1'b0, "latency", 8'hA5, 1'b0, 1'b0);
        tick();
        check("valid pulse", d0_valid, 1'b0);
      end
    join
    m_ready0 = 1'b0;
    ticks(2);

    // Table of frames on both instances
    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].sel, tbl[i].data, tbl[i].pbit, tbl[i].stopb);
      wait_valid(tbl[i].sel, $sformatf("vec%0d", i));
      check_hold(tbl[i].sel, $sformatf("vec%0d", i), tbl[i].exp_data, tbl[i].exp_ferr,
                 tbl[i].exp_perr);
      consume(tbl[i].sel, $sformatf("vec%0d", i));
      ticks(2);
    end

    // Overrun: second frame dropped while the first is still held
    send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
    check("ovr before", d0_ovr, 1'b0);
    send_frame(1'b0, 8'h81, 1'b0, 1'b1);
    ticks(2);
    check("ovr valid", d0_valid, 1'b1);
    check_hold(1'b0, "ovr keep", 8'h3C, 1'b0, 1'b0);
    check("ovr set", d0_ovr, 1'b1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("ovr clear", d0_ovr, 1'b0);
    consume(1'b0, "ovr");
    ticks(3 * CPB);
    check("ovr no second", d0_valid, 1'b0);

    // False start: a short low glitch
    rx0 = 1'b0;
    ticks(4);
    check("false busy", d0_busy, 1'b1);
    rx0 = 1'b1;
    ticks(2 * CPB);
    check("false idle", d0_busy, 1'b0);
    check("false valid", d0_valid, 1'b0);
    send_frame(1'b0, 8'h55, 1'b0, 1'b1);
    wait_valid(1'b0, "after false");
    check_hold(1'b0, "after false", 8'h55, 1'b0, 1'b0);
    consume(1'b0, "after false");
    ticks(2);

    // Break: 30 bit times low yields exactly one frame
    m_ready0 = 1'b1;
    brk_cnt = 0;
    brk_data = 8'hEE;
    brk_ferr = 1'b0;
    rx0 = 1'b0;
    for (int i = 0; i < 34 * CPB; i++) begin
      if (i == 30 * CPB) rx0 = 1'b1;
      tick();
      if (d0_valid) begin
        brk_cnt++;
        brk_data = d0_data;
        brk_ferr = d0_ferr;
      end
    end
    m_ready0 = 1'b0;
    check("break frames", brk_cnt, 1);
    check("break data", brk_data, 8'h00);
    check("break frame_err", brk_ferr, 1'b1);

    // Reset during data bit 4 with a held, errored byte present
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0);
    ticks(2);
    check_hold(1'b0, "pre-reset", 8'hC3, 1'b1, 1'b0);
    rv = 8'h12;
    rx0 = 1'b0;
    ticks(CPB);
    for (int b = 0; b < 4; b++) begin
      rx0 = rv[b];
      ticks(CPB);
    end
    rx0 = rv[4];
    ticks(CPB / 2);
    check("mid busy", d0_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid reset");
    tick();
    rst_n = 1'b1;
    rx0 = 1'b1;
    ticks(12 * CPB);
    check("post reset valid", d0_valid, 1'b0);
    send_frame(1'b0, 8'h34, 1'b0, 1'b1);
    wait_valid(1'b0, "post reset");
    check_hold(1'b0, "post reset", 8'h34, 1'b0, 1'b0);
    consume(1'b0, "post reset");
    ticks(2);

    // Random frames against a one-entry holding register model
    mfull = 1'b0;
    mferr = 1'b0;
    movr  = 1'b0;
    mdata = 8'h00;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      bit sb;
      b  = 8'($urandom);
      sb = ($urandom_range(3) != 0);
      send_frame(1'b0, b, 1'b0, sb);
      ticks(2);
      if (!mfull) begin
        mfull = 1'b1;
        mdata = b;
        mferr = !sb;
      end else begin
        movr = 1'b1;
      end
      check($sformatf("rnd%0d valid", i), d0_valid, mfull);
      check_hold(1'b0, $sformatf("rnd%0d", i), mdata, mferr, 1'b0);
      check($sformatf("rnd%0d overrun", i), d0_ovr, movr);
      if ($urandom_range(2) != 0) begin
        consume(1'b0, $sformatf("rnd%0d", i));
        mfull = 1'b0;
      end
      if ($urandom_range(3) == 0) begin
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        movr = 1'b0;
      end
      ticks($urandom_range(20));
    end

    // Random parity frames: error iff total count of ones disagrees with the parity sense
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      bit pb, sb, exp_perr;
      b  = 8'($urandom);
      pb = 1'($urandom_range(1));
      sb = ($urandom_range(3) != 0);
      exp_perr = ((($countones(b) + pb) % 2) != P_ODD);
      send_frame(1'b1, b, pb, sb);
      wait_valid(1'b1, $sformatf("prnd%0d", i));
      check_hold(1'b1, $sformatf("prnd%0d", i), b, !sb, exp_perr);
      consume(1'b1, $sformatf("prnd%0d", i));
      ticks(2 + $urandom_range(10));
    end

    check("parity inst overrun", d1_ovr, 1'b0);
    check("parity inst busy", d1_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
